// File: rtl/maze_pkg.sv
// Shared definitions for the maze path checker and the solver datapath:
// move codes, checker error codes and checker FSM states.
package maze_pkg;

  // Move codes; the bitwise complement of a code is the reverse move.
  typedef enum logic [1:0] {
    MV_UP    = 2'b00,
    MV_RIGHT = 2'b01,
    MV_LEFT  = 2'b10,
    MV_DOWN  = 2'b11
  } move_e;

  localparam logic [2:0] ERR_NONE    = 3'b000;
  localparam logic [2:0] ERR_OOB     = 3'b001;
  localparam logic [2:0] ERR_WALL    = 3'b010;
  localparam logic [2:0] ERR_SHORT   = 3'b011;
  localparam logic [2:0] ERR_REVISIT = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    READ,
    PASS,
    FAIL
  } state_e;

endpackage

// File: rtl/maze_step_calc.sv
// Combinational step: applies one move to a grid position and flags
// a step that leaves the 2^W x 2^W grid.
module maze_step_calc
  import maze_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [1:0]   mv,
  output logic [W-1:0] nxt_x,
  output logic [W-1:0] nxt_y,
  output logic         oob
);

  logic [W:0] ex;
  logic [W:0] ey;

  // W+1-bit arithmetic: both -1 and 2^W land with the top bit set.
  always_comb begin
    ex = {1'b0, x};
    ey = {1'b0, y};
    case (move_e'(mv))
      MV_UP:    ey = ey - (W+1)'(1);
      MV_RIGHT: ex = ex + (W+1)'(1);
      MV_LEFT:  ex = ex - (W+1)'(1);
      MV_DOWN:  ey = ey + (W+1)'(1);
      default:  ex = ex;
    endcase
    oob   = ex[W] | ey[W];
    nxt_x = ex[W-1:0];
    nxt_y = ey[W-1:0];
  end

endmodule

// File: rtl/maze_path_checker.sv
// Maze path checker: replays a move stream from the start cell, checks
// each step against the wall map and reports pass, or fail with a code.
// Optional revisit detection: define MAZE_PATH_REVISIT_CHECK_EN.
module maze_path_checker
  import maze_pkg::*;
#(
  parameter int W       = 4,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 15,
  parameter int GOAL_Y  = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mv_valid,
  input  logic [1:0]       mv,
  input  logic             mv_last,
  output logic             mv_ready,
  output logic             mem_rd,
  output logic [W-1:0]     mem_x,
  output logic [W-1:0]     mem_y,
  input  logic             mem_dout,
  output logic [W-1:0]     pos_x,
  output logic [W-1:0]     pos_y,
  output logic [CNT_W-1:0] move_cnt,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [2:0]       err_code
);

  state_e         state;
  logic [W-1:0]   nxt_x_q;
  logic [W-1:0]   nxt_y_q;
  logic           last_q;
  logic [W-1:0]   calc_x;
  logic [W-1:0]   calc_y;
  logic           calc_oob;
  logic           accept;
  logic           at_goal;

`ifdef MAZE_PATH_REVISIT_CHECK_EN
  localparam int START_IDX = START_Y * (2**W) + START_X;
  logic [2**(2*W)-1:0] visited;
`endif

  maze_step_calc #(.W(W)) u_step (
    .x     (pos_x),
    .y     (pos_y),
    .mv    (mv),
    .nxt_x (calc_x),
    .nxt_y (calc_y),
    .oob   (calc_oob)
  );

  // A start in the same cycle takes priority, so the move is not offered
  // as consumed and no read is launched for it.
  always_comb begin
    mv_ready = (state == ACCEPT) && !start;
    accept   = mv_ready && mv_valid;
    mem_rd   = accept && !calc_oob;
    mem_x    = mem_rd ? calc_x : '0;
    mem_y    = mem_rd ? calc_y : '0;
    at_goal  = (nxt_x_q == W'(GOAL_X)) && (nxt_y_q == W'(GOAL_Y));
  end

  // Checker FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pos_x    <= W'(START_X);
      pos_y    <= W'(START_Y);
      nxt_x_q  <= '0;
      nxt_y_q  <= '0;
      last_q   <= 1'b0;
      move_cnt <= '0;
      busy     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      err_code <= ERR_NONE;
`ifdef MAZE_PATH_REVISIT_CHECK_EN
      visited  <= '0;
`endif
    end else if (start) begin
      state    <= ACCEPT;
      pos_x    <= W'(START_X);
      pos_y    <= W'(START_Y);
      last_q   <= 1'b0;
      move_cnt <= '0;
      busy     <= 1'b1;
      pass     <= 1'b0;
      fail     <= 1'b0;
      err_code <= ERR_NONE;
`ifdef MAZE_PATH_REVISIT_CHECK_EN
      visited            <= '0;
      visited[START_IDX] <= 1'b1;
`endif
    end else begin
      case (state)
        ACCEPT: begin
          if (accept) begin
            last_q <= mv_last;
            if (calc_oob) begin
              state    <= FAIL;
              busy     <= 1'b0;
              fail     <= 1'b1;
              err_code <= ERR_OOB;
            end else begin
              nxt_x_q <= calc_x;
              nxt_y_q <= calc_y;
              state   <= READ;
            end
          end
        end
        READ: begin
          if (mem_dout) begin
            state    <= FAIL;
            busy     <= 1'b0;
            fail     <= 1'b1;
            err_code <= ERR_WALL;
          end
`ifdef MAZE_PATH_REVISIT_CHECK_EN
          else if (visited[{nxt_y_q, nxt_x_q}]) begin
            state    <= FAIL;
            busy     <= 1'b0;
            fail     <= 1'b1;
            err_code <= ERR_REVISIT;
          end
`endif
          else begin
            pos_x <= nxt_x_q;
            pos_y <= nxt_y_q;
            if (move_cnt != '1) move_cnt <= move_cnt + CNT_W'(1);
`ifdef MAZE_PATH_REVISIT_CHECK_EN
            visited[{nxt_y_q, nxt_x_q}] <= 1'b1;
`endif
            if (at_goal) begin
              state <= PASS;
              busy  <= 1'b0;
              pass  <= 1'b1;
            end else if (last_q) begin
              state    <= FAIL;
              busy     <= 1'b0;
              fail     <= 1'b1;
              err_code <= ERR_SHORT;
            end else begin
              state <= ACCEPT;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: doc/maze_path_checker.md
Name: maze_path_checker

Overview:
- Consumer end of the solver's move stream: accepts 2-bit moves and replays them from the start cell.
- Checks each step against the maze wall map through a read-only memory port.
- Reports PASS if the path reaches the goal cell, or FAIL with an error code.
- Sits downstream of the solver's output queue and is used in hardware self-check and in the bench scoreboard.

Parameters:
- W, 4: coordinate width; the grid is 2^W x 2^W.
- START_X, 0: start X.
- START_Y, 0: start Y.
- GOAL_X, 15: goal X.
- GOAL_Y, 15: goal Y.
- CNT_W, 8: width of the accepted-move counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  pulse; begin a new path check from (START_X,START_Y).
- mv_valid  in  1  move present on mv.
- mv  in  2  move code: 00 y-1, 01 x+1, 10 x-1, 11 y+1. The bitwise complement of a code is the reverse move.
- mv_last  in  1  qualifies mv as the final move of the path.
- mv_ready  out  1  checker accepts mv this cycle.
- mem_rd  out  1  wall-map read strobe.
- mem_x  out  W  read address X.
- mem_y  out  W  read address Y.
- mem_dout  in  1  wall bit, valid the cycle after mem_rd; 1 means blocked.
- pos_x  out  W  current replayed X.
- pos_y  out  W  current replayed Y.
- move_cnt  out  CNT_W  number of moves accepted and applied.
- busy  out  1  check in progress.
- pass  out  1  path reached goal legally; level, held.
- fail  out  1  path illegal; level, held.
- err_code  out  3  000 none, 001 out-of-bounds, 010 wall, 011 short (last move not at goal), 100 revisit (optional feature only).

Behaviour:
- Reset values:
  - State is IDLE.
  - pos is (START_X,START_Y).
  - move_cnt=0, mv_ready=0, mem_rd=0, busy=0, pass=0, fail=0, err_code=000.
  - mem_x and mem_y are 0.
- IDLE:
  - mv_ready=0.
  - When start=1: load pos to the start cell, clear move_cnt/pass/fail/err_code, go to ACCEPT.
- ACCEPT:
  - busy=1, mv_ready=1.
  - On mv_valid&mv_ready: compute nxt = pos + delta(mv) using W+1-bit signed arithmetic, and latch mv_last.
  - If nxt leaves [0, 2^W-1] on either axis, go to FAIL with err 001. No read is issued and pos is unchanged.
  - Otherwise drive mem_rd=1 with mem_x/mem_y=nxt the same cycle, and go to READ.
- READ:
  - mv_ready=0.
  - If mem_dout=1, go to FAIL with err 010; pos is unchanged.
  - Otherwise pos<=nxt and move_cnt increments, saturating at all-ones.
  - If nxt==goal, go to PASS. This applies whether or not mv_last is set; the goal terminates the path.
  - Else if the latched mv_last=1, go to FAIL with err 011.
  - Else return to ACCEPT.
- Throughput: one move per 2 cycles at most. Acceptance-to-pos-update latency is 2 edges.
- PASS / FAIL:
  - busy=0, mv_ready=0. pass or fail is held until the next start.
  - Further mv_valid is ignored and not consumed.
- start while busy: restart the check immediately from the start cell. Any in-flight read is discarded.
- Simultaneous start and mv_valid in IDLE: start wins; the move is not consumed, because mv_ready was 0 that cycle.
- A start cell equal to the goal is not special-cased; at least one move is required.
- Async reset mid-check: immediate return to reset values. The upstream queue must not assume the move was consumed.

Optional Feature:
- Macro: MAZE_PATH_REVISIT_CHECK_EN.
- Defined:
  - Adds a 2^(2W)-bit visited bitmap. It is cleared on start, and the start cell is then marked.
  - In READ, if the nxt cell is already marked, go to FAIL with err 100 (checked after the wall check). Otherwise mark it.
- Undefined: no bitmap; err 100 is never produced; revisits are legal.

Decomposition:
- Shared package maze_pkg holds:
  - move-code enum MV_UP=00, MV_RIGHT=01, MV_LEFT=10, MV_DOWN=11;
  - err_code constants;
  - FSM state enum IDLE/ACCEPT/READ/PASS/FAIL.
- The solver datapath imports the same move enum.
- One sub-module: maze_step_calc. It is combinational: pos+mv gives nxt and an out-of-bounds flag. It is shared with the solver's move translation.

Test Plan:
- Clear maze, start, then 15x01 followed by 15x11 with mv_last on the final move -> pass=1, pos=(15,15), move_cnt=30, err_code=000.
- From start, move 00 -> fail=1, err_code=001, pos=(0,0), move_cnt=0, mem_rd never asserted.
- Wall at (1,0), move 01 -> mem_rd with mem_x=1, mem_y=0; next cycle fail=1, err_code=010, pos stays (0,0).
- Moves 01,11 with mv_last on the second -> fail=1, err_code=011, pos=(1,1), move_cnt=2.
- start pulsed after 5 accepted moves -> pos=(0,0), move_cnt=0, busy=1, mv_ready=1 the next cycle.
- MAZE_PATH_REVISIT_CHECK_EN defined, moves 01,10 -> fail=1, err_code=100. Same stimulus with the macro undefined -> no fail, pos=(0,0), move_cnt=2.
